regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, 3, number of write requesters (fixed 3 for this revision); NREGS, 32, number of registers; IDLE_SEL, 63, write_select value that matches no register.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising clk edge.
REQ-004 req_valid  input  3  bit i = requester i has a pending write.
REQ-005 req_addr  input  18  requester i destination register at bits [6i+5:6i].
REQ-006 req_data  input  96  requester i write data at bits [32i+31:32i].
REQ-007 req_ready  output  3  bit i = requester i accepted this cycle (combinational, one-hot or zero).
REQ-008 init_start  input  1  request to clear all 32 registers to zero.
REQ-009 init_busy  output  1  high while the clear sweep runs.
REQ-010 write_select  output  6  register-file write index, registered; IDLE_SEL means no write.
REQ-011 write_in  output  32  register-file write data, registered.
REQ-012 grant_id  output  2  registered id of requester driving this cycle's write; 3 = none or init.

Function
REQ-013 FSM SHALL have two states: ARB (arbitrate requesters) and INIT (clear sweep).
REQ-014 In ARB with init_start=0, the block SHALL pick one valid requester by round-robin, searching from rr_ptr upward modulo 3.
REQ-015 The winner's req_ready bit SHALL be high in the same cycle; the transfer completes when req_valid[i] & req_ready[i] at the clock edge.
REQ-016 On a transfer, after that edge: write_select=req_addr of the winner, write_in=req_data of the winner, grant_id=i, rr_ptr=(i+1) mod 3.
REQ-017 With no valid requester: after the edge, write_select=63, write_in=0, grant_id=3; rr_ptr unchanged.
REQ-018 Write latency SHALL be exactly one cycle from acceptance to write_select/write_in presentation; the throughput is one write per cycle.
REQ-019 Requester addresses 32..63 SHALL be accepted normally and forwarded unchanged; they perform no register write.
REQ-020 In ARB with init_start=1: req_ready=0; after the edge, state=INIT, cnt=0, write_select=63, write_in=0, grant_id=3.
REQ-021 In INIT: req_ready=0; each edge loads write_select=cnt, write_in=0, grant_id=3, and increments cnt.
REQ-022 When cnt=31 in INIT, that edge SHALL return to ARB; registers 0..31 are written in order on 32 consecutive cycles.
REQ-023 init_busy SHALL equal (state==INIT); init_start during INIT SHALL be ignored.
REQ-024 rr_ptr SHALL be unchanged by an INIT sweep.
REQ-025 cnt SHALL be 5 bits wide and SHALL not wrap past 31 within a sweep.

Reset
REQ-026 Reset SHALL have priority over every other input, including reset asserted mid-INIT.
REQ-027 On reset: state=ARB, rr_ptr=0, cnt=0, write_select=63, write_in=0, grant_id=3, init_busy=0, req_ready=0.
REQ-028 A sweep aborted by reset SHALL not resume.

Verification
REQ-029 Reset, then req_valid=3'b001, addr0=5, data0=0xDEADBEEF for 1 cycle -> req_ready=001 that cycle; next cycle write_select=5, write_in=0xDEADBEEF, grant_id=0; following cycle write_select=63.
REQ-030 req_valid=111 held for 6 cycles after reset -> req_ready sequence 001,010,100,001,010,100; grant_id sequence 0,1,2,0,1,2 lagging by one cycle.
REQ-031 init_start pulse with req_valid=010 in the same cycle -> req_ready=000; init_busy high for exactly 32 cycles; write_select steps 0..31 with write_in=0; requester 1 is granted on the first cycle after init_busy falls.
REQ-032 Reset asserted at sweep step 10 -> next cycle init_busy=0, write_select=63, grant_id=3; no further sweep writes.
REQ-033 req_valid=001, addr0=40 -> accepted; next cycle write_select=40, grant_id=0.
REQ-034 After the grant in REQ-033, req_valid=101 -> requester 2 is granted first (rr_ptr=1 skips idle requester 1), then requester 0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester/init/register-file bundle for the write arbiter
interface regfile_write_arbiter_if;
  logic [2:0]  req_valid;
  logic [17:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        init_start;
  logic        init_busy;
  logic [5:0]  write_select;
  logic [31:0] write_in;
  logic [1:0]  grant_id;

  modport master (
    output req_valid, req_addr, req_data, init_start,
    input  req_ready, init_busy, write_select, write_in, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, init_start,
    output req_ready, init_busy, write_select, write_in, grant_id
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin register-file write arbiter with clear sweep
module regfile_write_arbiter #(
  parameter int NREQ     = 3,
  parameter int NREGS    = 32,
  parameter int IDLE_SEL = 63
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {ARB, INIT} state_t;

  localparam logic [5:0] IDLE     = 6'(IDLE_SEL);
  localparam logic [4:0] LAST_CNT = 5'(NREGS - 1);
  localparam logic [1:0] NO_GRANT = 2'd3;

  state_t      r_state;
  logic [1:0]  r_rr_ptr;
  logic [4:0]  r_cnt;
  logic [5:0]  r_write_select;
  logic [31:0] r_write_in;
  logic [1:0]  r_grant_id;

  logic        w_any;
  logic [1:0]  w_win;
  logic        w_arb_en;
  logic [2:0]  w_ready;
  logic [5:0]  w_win_addr;
  logic [31:0] w_win_data;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] t;
    t = (v >= 3'd3) ? (v - 3'd3) : v;
    return t[1:0];
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo 3
  always_comb begin
    w_any = 1'b0;
    w_win = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && bus.req_valid[wrap3({1'b0, r_rr_ptr} + 3'(k))]) begin
        w_any = 1'b1;
        w_win = wrap3({1'b0, r_rr_ptr} + 3'(k));
      end
    end
  end

  always_comb begin
    w_win_addr = bus.req_addr[5:0];
    w_win_data = bus.req_data[31:0];
    case (w_win)
      2'd1: begin
        w_win_addr = bus.req_addr[11:6];
        w_win_data = bus.req_data[63:32];
      end
      2'd2: begin
        w_win_addr = bus.req_addr[17:12];
        w_win_data = bus.req_data[95:64];
      end
      default: begin
        w_win_addr = bus.req_addr[5:0];
        w_win_data = bus.req_data[31:0];
      end
    endcase
  end

  assign w_arb_en = !reset && (r_state == ARB) && !bus.init_start;
  assign w_ready  = (w_arb_en && w_any) ? (3'b001 << w_win) : 3'b000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ARB;
      r_rr_ptr       <= 2'd0;
      r_cnt          <= 5'd0;
      r_write_select <= IDLE;
      r_write_in     <= 32'd0;
      r_grant_id     <= NO_GRANT;
    end else begin
      case (r_state)
        ARB: begin
          if (bus.init_start) begin
            r_state        <= INIT;
            r_cnt          <= 5'd0;
            r_write_select <= IDLE;
            r_write_in     <= 32'd0;
            r_grant_id     <= NO_GRANT;
          end else if (w_any) begin
            r_write_select <= w_win_addr;
            r_write_in     <= w_win_data;
            r_grant_id     <= w_win;
            r_rr_ptr       <= wrap3({1'b0, w_win} + 3'd1);
          end else begin
            r_write_select <= IDLE;
            r_write_in     <= 32'd0;
            r_grant_id     <= NO_GRANT;
          end
        end
        INIT: begin
          r_write_select <= {1'b0, r_cnt};
          r_write_in     <= 32'd0;
          r_grant_id     <= NO_GRANT;
          if (r_cnt == LAST_CNT) begin
            r_state <= ARB;
            r_cnt   <= 5'd0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.init_busy    = (r_state == INIT);
  assign bus.write_select = r_write_select;
  assign bus.write_in     = r_write_in;
  assign bus.grant_id     = r_grant_id;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus();

  regfile_write_arbiter #(.NREQ(3), .NREGS(32), .IDLE_SEL(63)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic [39:0] exp_q[$];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] wr(input logic [5:0] s, input logic [31:0] d, input logic [1:0] g);
    return {s, d, g};
  endfunction

  // Every presented write (real index or a requester grant) consumes one expectation
  always @(negedge clk) begin
    if (mon_en && (bus.write_select != 6'd63 || bus.grant_id != 2'd3)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got sel=%0d data=%h gid=%0d with empty queue",
                 bus.write_select, bus.write_in, bus.grant_id);
      end else begin
        chk("write", {bus.write_select, bus.write_in, bus.grant_id}, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [2:0] v, input logic [17:0] a, input logic [95:0] d,
                       input logic st, input logic [2:0] exp_rdy, input logic exp_busy);
    bus.req_valid  = v;
    bus.req_addr   = a;
    bus.req_data   = d;
    bus.init_start = st;
    @(negedge clk);
    chk("req_ready", {37'd0, bus.req_ready}, {37'd0, exp_rdy});
    chk("init_busy", {39'd0, bus.init_busy}, {39'd0, exp_busy});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outputs(input string nm);
    chk({nm, "_sel"},  {34'd0, bus.write_select}, {34'd0, 6'd63});
    chk({nm, "_data"}, {8'd0, bus.write_in}, 40'd0);
    chk({nm, "_gid"},  {38'd0, bus.grant_id}, {38'd0, 2'd3});
    chk({nm, "_busy"}, {39'd0, bus.init_busy}, 40'd0);
  endtask

  logic [17:0] a3;
  logic [95:0] d3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 3'b000;
    bus.req_addr   = 18'd0;
    bus.req_data   = 96'd0;
    bus.init_start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    idle_outputs("reset");
    chk("reset_ready", {37'd0, bus.req_ready}, 40'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Single accept from requester 0
    exp_q.push_back(wr(6'd5, 32'hDEADBEEF, 2'd0));
    drive(3'b001, {6'd0, 6'd0, 6'd5}, {64'd0, 32'hDEADBEEF}, 1'b0, 3'b001, 1'b0);
    drive(3'b000, 18'd0, 96'd0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    idle_outputs("after_single");
    @(posedge clk); #1;

    // Re-reset so round-robin starts from requester 0
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    a3 = {6'd12, 6'd11, 6'd10};
    d3 = {32'h2222_0002, 32'h1111_0001, 32'h0000_1000};
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(wr(6'd10, 32'h0000_1000, 2'd0));
      drive(3'b111, a3, d3, 1'b0, 3'b001, 1'b0);
      exp_q.push_back(wr(6'd11, 32'h1111_0001, 2'd1));
      drive(3'b111, a3, d3, 1'b0, 3'b010, 1'b0);
      exp_q.push_back(wr(6'd12, 32'h2222_0002, 2'd2));
      drive(3'b111, a3, d3, 1'b0, 3'b100, 1'b0);
    end
    drive(3'b000, 18'd0, 96'd0, 1'b0, 3'b000, 1'b0);

    // Full clear sweep with requester 1 waiting; second init_start mid-sweep is ignored
    drive(3'b010, a3, d3, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 32; i++) exp_q.push_back(wr(6'(i), 32'd0, 2'd3));
    for (int i = 0; i < 32; i++)
      drive(3'b010, a3, d3, (i == 5), 3'b000, 1'b1);
    exp_q.push_back(wr(6'd11, 32'h1111_0001, 2'd1));
    drive(3'b010, a3, d3, 1'b0, 3'b010, 1'b0);
    drive(3'b000, 18'd0, 96'd0, 1'b0, 3'b000, 1'b0);

    // Reset arriving at sweep step 10 aborts the sweep for good
    drive(3'b000, 18'd0, 96'd0, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(wr(6'(i), 32'd0, 2'd3));
      drive(3'b000, 18'd0, 96'd0, 1'b0, 3'b000, 1'b1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    idle_outputs("abort");
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive(3'b000, 18'd0, 96'd0, 1'b0, 3'b000, 1'b0);

    // Out-of-range address is forwarded unchanged
    exp_q.push_back(wr(6'd40, 32'hCAFE_0040, 2'd0));
    drive(3'b001, {6'd0, 6'd0, 6'd40}, {64'd0, 32'hCAFE_0040}, 1'b0, 3'b001, 1'b0);

    // rr_ptr=1 skips idle requester 1
    a3 = {6'd20, 6'd0, 6'd7};
    d3 = {32'hAAAA_0002, 32'd0, 32'h5555_0000};
    exp_q.push_back(wr(6'd20, 32'hAAAA_0002, 2'd2));
    drive(3'b101, a3, d3, 1'b0, 3'b100, 1'b0);
    exp_q.push_back(wr(6'd7, 32'h5555_0000, 2'd0));
    drive(3'b101, a3, d3, 1'b0, 3'b001, 1'b0);

    // Address 63 from a requester still shows up as a grant
    exp_q.push_back(wr(6'd63, 32'h0BAD_F00D, 2'd1));
    drive(3'b010, {6'd0, 6'd63, 6'd0}, {32'd0, 32'h0BAD_F00D, 32'd0}, 1'b0, 3'b010, 1'b0);

    for (int i = 0; i < 3; i++) drive(3'b000, 18'd0, 96'd0, 1'b0, 3'b000, 1'b0);
    chk("queue_empty", {8'd0, 32'(exp_q.size())}, 40'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
